// File: rtl/ee354_ssd_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver.
// The master supplies the nibbles and controls; the slave drives the pins.
interface ee354_ssd_scan_driver_if;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic        lz_suppress;
    logic [3:0]  an_n;
    logic [7:0]  cath_n;
    logic [1:0]  scan_idx;

    modport master (
        output digits_in, digit_en, dp_in, blink_en, lz_suppress,
        input  an_n, cath_n, scan_idx
    );

    modport slave (
        input  digits_in, digit_en, dp_in, blink_en, lz_suppress,
        output an_n, cath_n, scan_idx
    );
endinterface

// File: rtl/ee354_ssd_scan_driver.sv
// Four-digit common-anode scan driver with per-frame snapshot,
// anode guard time, leading-zero suppression, blink and decimal points.
module ee354_ssd_scan_driver #(
    parameter int SCAN_DIV_BITS = 18,
    parameter int GUARD_CYCLES  = 1024,
    parameter int BLINK_BIT     = 26
) (
    input  logic                         board_clk,
    input  logic                         Reset,
    ee354_ssd_scan_driver_if.slave       ssd
);
    localparam int CW = BLINK_BIT + 1;
    localparam logic [SCAN_DIV_BITS-1:0] GUARD_LIM = SCAN_DIV_BITS'(GUARD_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    scan_idx;
    logic          first;
    logic [15:0]   snap_dig;
    logic [3:0]    snap_en;
    logic [3:0]    snap_dp;
    logic [3:0]    snap_blink;
    logic          snap_lz;
    logic [3:0]    an_q;
    logic [7:0]    cath_q;

    logic          boundary;
    logic          guard;
    logic          lz3;
    logic          lz2;
    logic          lz1;
    logic [3:0]    blank_vec;
    logic [3:0]    nib;
    logic [3:0]    an_d;
    logic [7:0]    cath_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign boundary = (cnt[SCAN_DIV_BITS-1:0] == '0);
    assign guard    = (cnt[SCAN_DIV_BITS-1:0] < GUARD_LIM);

    // Leading zeros ripple from the leftmost digit; digit 0 always shows.
    assign lz3 = snap_lz & (snap_dig[15:12] == 4'h0);
    assign lz2 = lz3 & (snap_dig[11:8] == 4'h0);
    assign lz1 = lz2 & (snap_dig[7:4] == 4'h0);

    assign blank_vec = ~snap_en
                     | (snap_blink & {4{cnt[BLINK_BIT]}})
                     | {lz3, lz2, lz1, 1'b0};

    assign nib = snap_dig[{scan_idx, 2'b00} +: 4];

    always_comb begin
        an_d   = 4'b1111;
        cath_d = 8'hFF;
        if (!guard && !blank_vec[scan_idx]) begin
            an_d   = ~(4'b0001 << scan_idx);
            cath_d = {seg7(nib), ~snap_dp[scan_idx]};
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            scan_idx   <= 2'd3;
            first      <= 1'b1;
            snap_dig   <= 16'h0000;
            snap_en    <= 4'h0;
            snap_dp    <= 4'h0;
            snap_blink <= 4'h0;
            snap_lz    <= 1'b0;
            an_q       <= 4'b1111;
            cath_q     <= 8'hFF;
        end else begin
            cnt    <= cnt + 1'b1;
            first  <= 1'b0;
            an_q   <= an_d;
            cath_q <= cath_d;
            // New frame starts when scanning wraps back to digit 3.
            if (first || (boundary && scan_idx == 2'd0)) begin
                snap_dig   <= ssd.digits_in;
                snap_en    <= ssd.digit_en;
                snap_dp    <= ssd.dp_in;
                snap_blink <= ssd.blink_en;
                snap_lz    <= ssd.lz_suppress;
            end
            if (boundary && !first)
                scan_idx <= scan_idx - 2'd1;
        end
    end

    assign ssd.an_n     = an_q;
    assign ssd.cath_n   = cath_q;
    assign ssd.scan_idx = scan_idx;
endmodule

// File: tb/tb_ee354_ssd_scan_driver.sv
// Scoreboard bench for the seven-segment scan driver.
// Reference model works from elapsed count since reset.
module tb_ee354_ssd_scan_driver;
    localparam int SDB = 4;
    localparam int GC  = 2;
    localparam int BB  = 8;
    localparam int PER = 1 << SDB;
    localparam int BWRAP = 1 << (BB + 1);

    typedef struct {
        logic [3:0] an;
        logic [7:0] cath;
        logic [1:0] idx;
    } exp_t;

    logic board_clk = 1'b0;
    logic Reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    ee354_ssd_scan_driver_if ssd ();

    ee354_ssd_scan_driver #(
        .SCAN_DIV_BITS(SDB),
        .GUARD_CYCLES (GC),
        .BLINK_BIT    (BB)
    ) dut (
        .board_clk(board_clk),
        .Reset    (Reset),
        .ssd      (ssd)
    );

    always #5 board_clk = ~board_clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    exp_t        q[$];
    int          mc = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_en = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_bl = '0;
    logic        s_lz = 1'b0;
    logic [3:0]  prev_an = 4'hF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Digit owning the period that contains count c (c = cycles since release).
    function automatic int idx_of(input int c);
        if (c == 0) return 3;
        return 3 - (((c - 1) / PER) % 4);
    endfunction

    function automatic exp_t expect_at(input int c);
        exp_t e;
        int i;
        logic bl;
        logic [3:0] one;
        one = 4'b0001;
        e.an = 4'hF;
        e.cath = 8'hFF;
        e.idx = 2'd0;
        if ((c % PER) < GC) return e;
        i = idx_of(c);
        bl = !s_en[i]
           || (s_bl[i] && ((c % BWRAP) >= (BWRAP / 2)))
           || (s_lz && i > 0 && (s_dig >> (4 * i)) == 16'h0);
        if (bl) return e;
        e.an = ~(one << i);
        e.cath = {seg_tab[s_dig[4*i +: 4]], ~s_dp[i]};
        return e;
    endfunction

    always @(posedge board_clk) begin
        exp_t e;
        if (Reset) begin
            mc = 0;
            s_dig = '0; s_en = '0; s_dp = '0; s_bl = '0; s_lz = 1'b0;
            q.delete();
        end else begin
            e = expect_at(mc);
            e.idx = 2'(idx_of(mc + 1));
            q.push_back(e);
            if (mc == 0 || ((mc % PER) == 0 && idx_of(mc) == 0)) begin
                s_dig = ssd.digits_in;
                s_en  = ssd.digit_en;
                s_dp  = ssd.dp_in;
                s_bl  = ssd.blink_en;
                s_lz  = ssd.lz_suppress;
            end
            mc++;
        end
    end

    always @(negedge board_clk) begin
        exp_t e;
        if (Reset) begin
            chk("rst_an", 32'(ssd.an_n), 32'hF);
            chk("rst_cath", 32'(ssd.cath_n), 32'hFF);
            chk("rst_idx", 32'(ssd.scan_idx), 32'd3);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("an_n", 32'(ssd.an_n), 32'(e.an));
            chk("cath_n", 32'(ssd.cath_n), 32'(e.cath));
            chk("scan_idx", 32'(ssd.scan_idx), 32'(e.idx));
        end
        chk("one_hot_an", 32'($countones(~ssd.an_n) <= 1), 32'd1);
        chk("guard_gap",
            32'(prev_an == 4'hF || ssd.an_n == 4'hF || ssd.an_n == prev_an), 32'd1);
        prev_an = ssd.an_n;
    end

    task automatic set_in(input logic [15:0] d, input logic [3:0] en,
                          input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        ssd.digits_in   = d;
        ssd.digit_en    = en;
        ssd.dp_in       = dp;
        ssd.blink_en    = bl;
        ssd.lz_suppress = lz;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge board_clk);
        #1;
    endtask

    task automatic wait_model(input int want_idx, input int want_lo, input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            if (idx_of(mc) == want_idx && (want_lo < 0 || (mc % PER) == want_lo)) break;
            step(1);
        end
        if (k == 300) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int found;
        logic [15:0] d;
        set_in(16'h12AF, 4'hF, 4'h0, 4'h0, 1'b0);
        step(3);
        Reset = 1'b0;
        step(80);

        wait_model(2, 5, "mid_d2");
        set_in(16'h3456, 4'hF, 4'h0, 4'h0, 1'b0);
        step(140);

        set_in(16'h0007, 4'hF, 4'h0, 4'h0, 1'b1);
        step(70);
        set_in(16'h0000, 4'hF, 4'h0, 4'h0, 1'b1);
        step(70);
        set_in(16'h0A00, 4'hF, 4'h0, 4'h0, 1'b1);
        step(70);

        set_in(16'h12AF, 4'hF, 4'b0100, 4'b0001, 1'b0);
        step(600);

        wait_model(1, 8, "mid_d1");
        chk("pre_rst_active", 32'(ssd.an_n), 32'b1101);
        Reset = 1'b1;
        #1;
        chk("async_an", 32'(ssd.an_n), 32'hF);
        chk("async_cath", 32'(ssd.cath_n), 32'hFF);
        chk("async_idx", 32'(ssd.scan_idx), 32'd3);
        step(3);
        Reset = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            step(1);
            if (ssd.an_n != 4'hF) begin
                found = 1;
                chk("first_lit", 32'(ssd.an_n), 32'b0111);
                chk("first_lit_k", 32'(k), 32'd2);
            end
        end
        if (found == 0) chk("first_lit_timeout", 32'd0, 32'd1);
        step(60);

        for (int it = 0; it < 40; it++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 3) == 0) d = d & 16'h000F;
            set_in(d, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            step($urandom_range(5, 150));
            if ($urandom_range(0, 7) == 0) begin
                Reset = 1'b1;
                step($urandom_range(1, 3));
                Reset = 1'b0;
            end
        end
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
